// File: rtl/fft_stage_ctrl.sv
// FFT stage controller: configures the PE chain, admits frames with a
// bounded number in flight, and tracks completed output frames.
module fft_stage_ctrl #(
    parameter int MAX_SET      = 10,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_valid,
    input  logic [3:0]             cfg_set,
    input  logic [2*MAX_SET-1:0]   cfg_scale,
    output logic                   cfg_ready,
    input  logic                   drain_req,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic                   pe_in_valid,
    input  logic                   pe_inter_ready,
    input  logic                   pe_out_valid,
    output logic [MAX_SET-1:0]     select,
    output logic [2*MAX_SET-1:0]   scaling,
    output logic                   frame_done,
    output logic                   busy,
    output logic                   err
);

    localparam int IW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [3:0]         SET_HI  = 4'(MAX_SET);
    localparam logic [MAX_SET-1:0] CNT_ONE = MAX_SET'(1);
    localparam logic [IW-1:0]      INF_ONE = IW'(1);
    localparam logic [IW-1:0]      INF_MAX = IW'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t state, state_nxt;

    logic [3:0]         set_q;
    logic [MAX_SET-1:0] in_cnt;
    logic [MAX_SET-1:0] out_cnt;
    logic [MAX_SET-1:0] last;
    logic [MAX_SET:0]   span;
    logic [IW-1:0]      inflight;
    logic [MAX_SET-1:0] sel_cfg;

    logic accept;
    logic cfg_ok;
    logic admit_state;
    logic room;
    logic in_wrap;
    logic out_bad;
    logic out_hit;
    logic out_wrap;
    logic all_empty;

    // last sample index of a frame, 2^set - 1 (mod 2^MAX_SET)
    assign span = {{MAX_SET{1'b0}}, 1'b1} << set_q;
    assign last = span[MAX_SET-1:0] - CNT_ONE;

    assign cfg_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = cfg_valid && cfg_ready;
    assign cfg_ok    = (cfg_set >= 4'd3) && (cfg_set <= SET_HI);

    always_comb begin
        sel_cfg = '0;
        for (int k = 0; k < MAX_SET; k++) begin
            sel_cfg[k] = (4'(MAX_SET - k) <= cfg_set);
        end
    end

    // in DRAIN only the partially admitted frame may continue
    assign admit_state = (state == RUN) ||
                         ((state == DRAIN) && (in_cnt != '0));
    assign room        = (in_cnt != '0) || (inflight < INF_MAX);
    assign s_ready     = admit_state && pe_inter_ready && room;
    assign pe_in_valid = s_valid && s_ready;

    assign in_wrap  = pe_in_valid && (in_cnt == last);
    assign out_bad  = pe_out_valid && (inflight == '0) && (out_cnt == '0);
    assign out_hit  = pe_out_valid && !out_bad;
    assign out_wrap = out_hit && (out_cnt == last);

    assign all_empty = (in_cnt == '0) && (out_cnt == '0) && (inflight == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept && cfg_ok) state_nxt = RUN;
            RUN:     if (drain_req) state_nxt = DRAIN;
            DRAIN:   if (all_empty) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            select     <= '0;
            scaling    <= '0;
            set_q      <= '0;
            in_cnt     <= '0;
            out_cnt    <= '0;
            inflight   <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            frame_done <= out_wrap;

            if (accept) begin
                if (cfg_ok) begin
                    select  <= sel_cfg;
                    scaling <= cfg_scale;
                    set_q   <= cfg_set;
                    err     <= 1'b0;
                end else begin
                    err <= 1'b1;
                end
            end
            if (out_bad) begin
                err <= 1'b1;
            end

            if (pe_in_valid) begin
                in_cnt <= in_wrap ? '0 : in_cnt + CNT_ONE;
            end
            if (out_hit) begin
                out_cnt <= out_wrap ? '0 : out_cnt + CNT_ONE;
            end

            // simultaneous admit and retire cancel out
            if (in_wrap && !out_wrap) begin
                inflight <= inflight + INF_ONE;
            end else if (out_wrap && !in_wrap && (inflight != '0)) begin
                inflight <= inflight - INF_ONE;
            end
        end
    end

endmodule
